axi_lite_regbank: RTL and testbench



---
 rtl/axi_lite_regbank.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
//
// Parametrised AXI4-Lite slave register bank. Holds C_NUM_REGS registers of
// C_DATA_WIDTH bits each. Supports byte-strobe writes, AW and W channels that
// may arrive in any order, and independent read and write paths. Register
// contents and per-register write strobes are exposed to user logic.
//
// Optional feature macro: AXI_REGBANK_ERR_RESP_EN
//   defined   -> out-of-range accesses answer DECERR (2'b11)
//   undefined -> out-of-range accesses answer OKAY (writes dropped, reads 0)
//
// Parameters:
//   C_DATA_WIDTH  bus / register width (32 or 64)
//   C_ADDR_WIDTH  AXI address width
//   C_NUM_REGS    number of registers (2..256)
//   C_RESET_VALUE reset value loaded into every register
//
// Ports:
//   s_axi_aclk        clock, all logic on the rising edge
//   s_axi_areset      asynchronous active-high reset
//   s_axi_aw*         write address channel (awprot ignored)
//   s_axi_w*          write data channel with byte strobes
//   s_axi_b*          write response channel
//   s_axi_ar*         read address channel (arprot ignored)
//   s_axi_r*          read data channel
//   reg_out           flattened registers, reg i at [i*DW +: DW]
//   wr_pulse          one-cycle strobe, bit i high the cycle after reg i write
// ---------------------------------------------------------------------------
module axi_lite_regbank #(
    parameter int                      C_DATA_WIDTH  = 32,
    parameter int                      C_ADDR_WIDTH  = 12,
    parameter int                      C_NUM_REGS    = 8,
    parameter logic [C_DATA_WIDTH-1:0] C_RESET_VALUE = '0
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_areset,
    input  logic [C_ADDR_WIDTH-1:0]            s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]            s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]          s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]            s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]              wr_pulse
);

    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = C_ADDR_WIDTH - LSB;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_REGBANK_ERR_RESP_EN
    localparam logic [1:0] RESP_OOR  = 2'b11;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} wrState_t;
    typedef enum logic {R_IDLE, R_DATA} rdState_t;

    // Write channel state
    wrState_t               r_wrState;
    logic                   r_awReady;
    logic                   r_wReady;
    logic                   r_bValid;
    logic [1:0]             r_bResp;
    logic                   r_awHeld;
    logic                   r_wHeld;
    logic [IDX_W-1:0]       r_awIdx;
    logic [C_DATA_WIDTH-1:0] r_wData;
    logic [STRB_W-1:0]      r_wStrb;

    // Register storage
    logic [C_DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  r_wrPulse;

    // Read channel state
    rdState_t               r_rdState;
    logic                   r_arReady;
    logic                   r_rValid;
    logic [C_DATA_WIDTH-1:0] r_rData;
    logic [1:0]             r_rResp;

    // Write-side combinational helpers
    logic                   w_awFire;
    logic                   w_wFire;
    logic                   w_awHave;
    logic                   w_wHave;
    logic                   w_commit;
    logic [IDX_W-1:0]       w_wrIdx;
    logic [C_DATA_WIDTH-1:0] w_wrData;
    logic [STRB_W-1:0]      w_wrStrb;
    logic                   w_wrInRange;

    // Read-side combinational helpers
    logic                   w_arFire;
    logic [IDX_W-1:0]       w_arIdx;
    logic                   w_arInRange;
    logic [C_DATA_WIDTH-1:0] w_rdValue;

    // Protection bits and the byte-offset address bits carry no meaning here.
    logic                   w_unused;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    // A channel counts as "present" for the commit decision if it was held
    // from an earlier cycle or is handshaking right now, so a write that
    // completes its last handshake at edge k commits at that same edge.
    assign w_awFire    = s_axi_awvalid && r_awReady;
    assign w_wFire     = s_axi_wvalid && r_wReady;
    assign w_awHave    = r_awHeld || w_awFire;
    assign w_wHave     = r_wHeld || w_wFire;
    assign w_commit    = (r_wrState == W_IDLE) && w_awHave && w_wHave;
    assign w_wrIdx     = w_awFire ? s_axi_awaddr[C_ADDR_WIDTH-1:LSB] : r_awIdx;
    assign w_wrData    = w_wFire ? s_axi_wdata : r_wData;
    assign w_wrStrb    = w_wFire ? s_axi_wstrb : r_wStrb;
    assign w_wrInRange = int'(w_wrIdx) < C_NUM_REGS;

    assign w_arFire    = s_axi_arvalid && r_arReady;
    assign w_arIdx     = s_axi_araddr[C_ADDR_WIDTH-1:LSB];
    assign w_arInRange = int'(w_arIdx) < C_NUM_REGS;

    // Read mux: an index beyond the bank matches nothing and yields zero.
    always_comb begin
        w_rdValue = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (int'(w_arIdx) == i) begin
                w_rdValue = r_regs[i];
            end
        end
    end

    // Write FSM. In W_IDLE each channel's ready drops once its beat is held,
    // so AW and W are captured independently. Ready flags are registered,
    // which makes them rise on the first edge after reset release.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_wrState <= W_IDLE;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_awIdx   <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
        end else begin
            case (r_wrState)
                W_IDLE: begin
                    if (w_awFire) begin
                        r_awIdx <= s_axi_awaddr[C_ADDR_WIDTH-1:LSB];
                    end
                    if (w_wFire) begin
                        r_wData <= s_axi_wdata;
                        r_wStrb <= s_axi_wstrb;
                    end
                    if (w_commit) begin
                        r_wrState <= W_RESP;
                        r_awReady <= 1'b0;
                        r_wReady  <= 1'b0;
                        r_awHeld  <= 1'b1;
                        r_wHeld   <= 1'b1;
                        r_bValid  <= 1'b1;
                        r_bResp   <= w_wrInRange ? RESP_OKAY : RESP_OOR;
                    end else begin
                        r_awHeld  <= w_awHave;
                        r_wHeld   <= w_wHave;
                        r_awReady <= !w_awHave;
                        r_wReady  <= !w_wHave;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wrState <= W_IDLE;
                        r_bValid  <= 1'b0;
                        r_awHeld  <= 1'b0;
                        r_wHeld   <= 1'b0;
                        r_awReady <= 1'b1;
                        r_wReady  <= 1'b1;
                    end
                end
                default: begin
                    r_wrState <= W_IDLE;
                end
            endcase
        end
    end

    // Register bank update. Only strobed bytes change; an out-of-range
    // commit leaves every register and pulse untouched.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= C_RESET_VALUE;
            end
            r_wrPulse <= '0;
        end else begin
            r_wrPulse <= '0;
            if (w_commit && w_wrInRange) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (int'(w_wrIdx) == i) begin
                        r_wrPulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_wrStrb[b]) begin
                                r_regs[i][b*8 +: 8] <= w_wrData[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read FSM. Data is sampled from the registers as they were before the
    // edge, so a same-edge write to the same register returns the old value.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rdState <= R_IDLE;
            r_arReady <= 1'b0;
            r_rValid  <= 1'b0;
            r_rData   <= '0;
            r_rResp   <= RESP_OKAY;
        end else begin
            case (r_rdState)
                R_IDLE: begin
                    if (w_arFire) begin
                        r_rdState <= R_DATA;
                        r_arReady <= 1'b0;
                        r_rValid  <= 1'b1;
                        r_rData   <= w_rdValue;
                        r_rResp   <= w_arInRange ? RESP_OKAY : RESP_OOR;
                    end else begin
                        r_arReady <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rdState <= R_IDLE;
                        r_rValid  <= 1'b0;
                        r_arReady <= 1'b1;
                    end
                end
                default: begin
                    r_rdState <= R_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_regOut
        assign reg_out[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = r_regs[gi];
    end

    assign s_axi_awready = r_awReady;
    assign s_axi_wready  = r_wReady;
    assign s_axi_bvalid  = r_bValid;
    assign s_axi_bresp   = r_bResp;
    assign s_axi_arready = r_arReady;
    assign s_axi_rvalid  = r_rValid;
    assign s_axi_rdata   = r_rData;
    assign s_axi_rresp   = r_rResp;
    assign wr_pulse      = r_wrPulse;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regbank
//
// Self-checking bench for axi_lite_regbank with default parameters
// (32-bit data, 12-bit address, 8 registers, reset value 0). Expected values
// come from a per-register array model updated with byte masks.
// ---------------------------------------------------------------------------
module tb_axi_lite_regbank;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int NREGS = 8;
    localparam int SW    = DW / 8;

    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_REGBANK_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = 2'b11;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [AW-1:0]         s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [DW-1:0]         s_axi_wdata;
    logic [SW-1:0]         s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [AW-1:0]         s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [DW-1:0]         s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;
    logic [NREGS*DW-1:0]   reg_out;
    logic [NREGS-1:0]      wr_pulse;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: plain array of register values
    logic [DW-1:0] model [NREGS];

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .C_DATA_WIDTH (DW),
        .C_ADDR_WIDTH (AW),
        .C_NUM_REGS   (NREGS),
        .C_RESET_VALUE('0)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (3'b000),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (3'b000),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .reg_out      (reg_out),
        .wr_pulse     (wr_pulse)
    );

    // Flatten the model the same way reg_out is laid out
    function automatic logic [NREGS*DW-1:0] modelFlat();
        logic [NREGS*DW-1:0] f;
        for (int i = 0; i < NREGS; i++) begin
            f[i*DW +: DW] = model[i];
        end
        return f;
    endfunction

    // Full write transaction; AW and W are presented after independent
    // delays and B is accepted after bDelay cycles of back-pressure.
    task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int awDelay,
                           input int wDelay, input int bDelay);
        int               idx;
        bit               inRange;
        bit               awDone;
        bit               wDone;
        bit               awFire;
        bit               wFire;
        int               cyc;
        logic [DW-1:0]    mask;
        logic [NREGS-1:0] expPulse;
        logic [1:0]       expResp;
        idx     = int'(addr[AW-1:2]);
        inRange = idx < NREGS;
        awDone  = 1'b0;
        wDone   = 1'b0;
        cyc     = 0;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_bready = 1'b0;
        while (!(awDone && wDone) && cyc < 40) begin
            s_axi_awvalid = !awDone && (cyc >= awDelay);
            s_axi_wvalid  = !wDone && (cyc >= wDelay);
            awFire = s_axi_awvalid && s_axi_awready;
            wFire  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            #1;
            if (awFire) begin
                awDone = 1'b1;
                s_axi_awvalid = 1'b0;
            end
            if (wFire) begin
                wDone = 1'b1;
                s_axi_wvalid = 1'b0;
            end
            cyc++;
            if (!(awDone && wDone)) begin
                checkCount++;
                if (s_axi_bvalid !== 1'b0)
                    $display("[TB] FAIL early_bvalid: got %b expected 0 (cycle %0d)", s_axi_bvalid, cyc);
                else
                    passCount++;
            end
        end
        if (!(awDone && wDone)) begin
            checkCount++;
            $display("[TB] FAIL write_timeout: got aw=%b w=%b expected both handshaked", awDone, wDone);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end

        for (int b = 0; b < SW; b++) mask[b*8 +: 8] = {8{strb[b]}};
        expPulse = '0;
        if (inRange) begin
            model[idx]    = (model[idx] & ~mask) | (data & mask);
            expPulse[idx] = 1'b1;
        end
        expResp = inRange ? OKAY : OOR_RESP;

        checkCount++;
        if (s_axi_bvalid !== 1'b1)
            $display("[TB] FAIL bvalid_rise: got %b expected 1", s_axi_bvalid);
        else
            passCount++;
        checkCount++;
        if (s_axi_bresp !== expResp)
            $display("[TB] FAIL bresp: got %b expected %b (addr %h)", s_axi_bresp, expResp, addr);
        else
            passCount++;
        checkCount++;
        if (wr_pulse !== expPulse)
            $display("[TB] FAIL wr_pulse: got %b expected %b (addr %h)", wr_pulse, expPulse, addr);
        else
            passCount++;
        checkCount++;
        if (reg_out !== modelFlat())
            $display("[TB] FAIL reg_out: got %h expected %h", reg_out, modelFlat());
        else
            passCount++;
        checkCount++;
        if ({s_axi_awready, s_axi_wready} !== 2'b00)
            $display("[TB] FAIL ready_in_resp: got %b expected 00", {s_axi_awready, s_axi_wready});
        else
            passCount++;

        for (int k = 0; k < bDelay; k++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if ({s_axi_bvalid, s_axi_bresp} !== {1'b1, expResp})
                $display("[TB] FAIL b_hold: got %b expected %b", {s_axi_bvalid, s_axi_bresp}, {1'b1, expResp});
            else
                passCount++;
            checkCount++;
            if (wr_pulse !== '0)
                $display("[TB] FAIL pulse_width: got %b expected 0", wr_pulse);
            else
                passCount++;
        end

        s_axi_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
        checkCount++;
        if ({s_axi_bvalid, wr_pulse} !== {1'b0, {NREGS{1'b0}}})
            $display("[TB] FAIL b_done: got bvalid=%b pulse=%b expected 0 and 0", s_axi_bvalid, wr_pulse);
        else
            passCount++;
    endtask

    // Full read transaction with rDelay cycles of R back-pressure.
    task automatic doRead(input logic [AW-1:0] addr, input int rDelay, output logic [DW-1:0] got);
        int            idx;
        bit            inRange;
        int            cyc;
        logic [DW-1:0] expData;
        logic [1:0]    expResp;
        idx     = int'(addr[AW-1:2]);
        inRange = idx < NREGS;
        expData = inRange ? model[idx] : '0;
        expResp = inRange ? OKAY : OOR_RESP;
        got     = '0;
        cyc     = 0;
        s_axi_rready = 1'b0;
        while (!s_axi_arready && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!s_axi_arready) begin
            checkCount++;
            $display("[TB] FAIL read_timeout: got arready=0 expected 1");
            return;
        end
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        got = s_axi_rdata;
        checkCount++;
        if (s_axi_rvalid !== 1'b1)
            $display("[TB] FAIL rvalid_rise: got %b expected 1", s_axi_rvalid);
        else
            passCount++;
        checkCount++;
        if (s_axi_rdata !== expData)
            $display("[TB] FAIL rdata: got %h expected %h (addr %h)", s_axi_rdata, expData, addr);
        else
            passCount++;
        checkCount++;
        if (s_axi_rresp !== expResp)
            $display("[TB] FAIL rresp: got %b expected %b (addr %h)", s_axi_rresp, expResp, addr);
        else
            passCount++;
        for (int k = 0; k < rDelay; k++) begin
            @(posedge clk);
            #1;
            checkCount++;
            if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, expData, expResp})
                $display("[TB] FAIL r_hold: got %b/%h/%b expected 1/%h/%b",
                         s_axi_rvalid, s_axi_rdata, s_axi_rresp, expData, expResp);
            else
                passCount++;
        end
        s_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
        checkCount++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01)
            $display("[TB] FAIL r_done: got rvalid/arready=%b expected 01", {s_axi_rvalid, s_axi_arready});
        else
            passCount++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0)
            $display("[TB] FAIL reset_handshake: got %b expected 00000",
                     {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
        else
            passCount++;
        checkCount++;
        if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse} !== '0)
            $display("[TB] FAIL reset_payload: got %h expected 0", {s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse});
        else
            passCount++;
        checkCount++;
        if (reg_out !== '0)
            $display("[TB] FAIL reset_regs: got %h expected 0", reg_out);
        else
            passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000)
            $display("[TB] FAIL ready_before_edge: got %b expected 000", {s_axi_awready, s_axi_wready, s_axi_arready});
        else
            passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111)
            $display("[TB] FAIL ready_after_edge: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        else
            passCount++;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic test_basic_rw();
        logic [DW-1:0] got;
        for (int i = 0; i < 4; i++) doWrite(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) doRead(AW'(i * 4), 0, got);
    endtask

    task automatic test_strobe();
        logic [DW-1:0] got;
        doWrite(12'h010, 32'hAABBCCDD, 4'hF, 0, 0, 1);
        doWrite(12'h010, 32'h11223344, 4'b0101, 1, 0, 0);
        doRead(12'h010, 1, got);
        checkCount++;
        if (got !== 32'hAA22CC44)
            $display("[TB] FAIL strobe_merge: got %h expected AA22CC44", got);
        else
            passCount++;
    endtask

    task automatic test_aw_w_order();
        logic [DW-1:0] got;
        doWrite(12'h014, 32'hCAFE0001, 4'hF, 3, 0, 0);
        doWrite(12'h018, 32'hCAFE0002, 4'hF, 0, 3, 2);
        doRead(12'h014, 0, got);
        doRead(12'h018, 0, got);
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] got;
        doWrite(12'h040, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        doRead(12'h040, 1, got);
        doRead(12'hFFC, 0, got);
        doWrite(12'h01D, 32'h0BADF00D, 4'hF, 0, 1, 0);
        doRead(12'h01F, 0, got);
    endtask

    task automatic test_same_edge();
        logic [DW-1:0] got;
        int cyc;
        doWrite(12'h008, 32'h5, 4'hF, 0, 0, 0);
        cyc = 0;
        while (!(s_axi_awready && s_axi_wready && s_axi_arready) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        s_axi_awaddr  = 12'h008;
        s_axi_wdata   = 32'h9;
        s_axi_wstrb   = 4'hF;
        s_axi_araddr  = 12'h008;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_arvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        checkCount++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_rdata} !== {2'b11, 32'h5})
            $display("[TB] FAIL same_edge_old: got %b%b/%h expected 11/00000005",
                     s_axi_rvalid, s_axi_bvalid, s_axi_rdata);
        else
            passCount++;
        model[2] = 32'h9;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        doRead(12'h008, 0, got);
    endtask

    task automatic test_random();
        logic [DW-1:0] got;
        logic [AW-1:0] addr;
        logic [SW-1:0] strb;
        int idx;
        for (int n = 0; n < 40; n++) begin
            idx  = int'($urandom_range(0, 11));
            addr = AW'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                strb = SW'($urandom_range(0, 15));
                doWrite(addr, $urandom, strb, int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                doRead(addr, int'($urandom_range(0, 2)), got);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got;
        s_axi_awaddr  = 12'h004;
        s_axi_wdata   = 32'h12345678;
        s_axi_wstrb   = 4'hF;
        s_axi_bready  = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checkCount++;
        if (s_axi_bvalid !== 1'b1)
            $display("[TB] FAIL pre_reset_bvalid: got %b expected 1", s_axi_bvalid);
        else
            passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready, wr_pulse} !== '0)
            $display("[TB] FAIL abort_handshake: got %b expected 0",
                     {s_axi_bvalid, s_axi_awready, s_axi_wready, wr_pulse});
        else
            passCount++;
        checkCount++;
        if (reg_out !== '0)
            $display("[TB] FAIL abort_regs: got %h expected 0", reg_out);
        else
            passCount++;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Capture only an AW, then reset: the held address must be dropped
        s_axi_awaddr  = 12'h008;
        s_axi_awvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        checkCount++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010)
            $display("[TB] FAIL aw_held: got %b expected 010", {s_axi_awready, s_axi_wready, s_axi_bvalid});
        else
            passCount++;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        doWrite(12'h00C, 32'h0000600D, 4'hF, 3, 0, 0);
        doRead(12'h008, 0, got);
        doRead(12'h00C, 0, got);
    endtask

    initial begin
        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        test_reset();
        test_basic_rw();
        test_strobe();
        test_aw_w_order();
        test_out_of_range();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit expired expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
